// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU memory-path types for the cache/RAM arbiter
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - cache-side and RAM-side signals of the memory arbiter
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    logic      err;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter onto one RAM port, dcache priority with icache anti-starvation
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic            CLK,
    input  logic            RST,
    mem_arbiter_if.master   bus
);

    arb_state_t       state, state_next;
    logic [CNT_W-1:0] starve_cnt, cnt_next;
    logic             err_q;
    logic             d_req;
    logic             i_forced;

    assign d_req    = bus.dREN | bus.dWEN;
    assign i_forced = bus.iREN && (starve_cnt == CNT_W'(STARVE_MAX));
    assign bus.err  = err_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_next;
            starve_cnt <= cnt_next;
            if (state != IDLE && bus.ramstate == ERROR)
                err_q <= 1'b1;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = starve_cnt;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = bus.ramload;
        bus.dload    = bus.ramload;

        case (state)
            IDLE: begin
                if (!bus.iREN)
                    cnt_next = '0;
                if (d_req && !i_forced) begin
                    state_next = DSERV;
                    // Only dcache wins that overtake a waiting icache count toward starvation.
                    if (bus.iREN && starve_cnt != CNT_W'(STARVE_MAX))
                        cnt_next = starve_cnt + CNT_W'(1);
                end else if (bus.iREN) begin
                    state_next = ISERV;
                    cnt_next   = '0;
                end
            end
            DSERV: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (!d_req) begin
                    state_next = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    bus.dwait  = 1'b0;
                    state_next = IDLE;
                end
            end
            ISERV: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN;
                if (!bus.iREN) begin
                    state_next = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    bus.iwait  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int STARVE_MAX = 4;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: who currently owns the RAM (0 none, 1 dcache, 2 icache) and how many
    // dcache grants have overtaken a waiting icache.
    int  owner;
    int  streak;
    bit  err_m;
    int  trace[$];

    logic      m_ir, m_dr, m_dw;
    ramstate_t m_rs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner  = 0;
        streak = 0;
        err_m  = 0;
    endtask

    task automatic do_reset();
        RST          = 1'b1;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramstate = FREE;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        trace.delete();
    endtask

    task automatic drive_check(input logic ir, input word_t ia, input logic dr, input logic dw,
                               input word_t da, input word_t ds, input ramstate_t rs, input word_t rl);
        logic  e_ren, e_wen, e_iw, e_dw;
        word_t e_addr, e_store;
        bus.iREN = ir; bus.iaddr = ia; bus.dREN = dr; bus.dWEN = dw;
        bus.daddr = da; bus.dstore = ds; bus.ramstate = rs; bus.ramload = rl;
        m_ir = ir; m_dr = dr; m_dw = dw; m_rs = rs;
        #1;
        e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1; e_addr = '0; e_store = '0;
        if (owner == 1) begin
            e_addr  = da;
            e_store = ds;
            e_wen   = dw;
            e_ren   = dr && !dw;
            e_dw    = !((dr || dw) && rs == ACCESS);
        end else if (owner == 2) begin
            e_addr = ia;
            e_ren  = ir;
            e_iw   = !(ir && rs == ACCESS);
        end
        check("iwait",    32'(bus.iwait),  32'(e_iw));
        check("dwait",    32'(bus.dwait),  32'(e_dw));
        check("ramREN",   32'(bus.ramREN), 32'(e_ren));
        check("ramWEN",   32'(bus.ramWEN), 32'(e_wen));
        check("ramaddr",  bus.ramaddr,     e_addr);
        check("ramstore", bus.ramstore,    e_store);
        check("err",      32'(bus.err),    32'(err_m));
        if (!e_iw) check("iload", bus.iload, rl);
        if (!e_dw) check("dload", bus.dload, rl);
        if (!bus.dwait) trace.push_back(1);
        if (!bus.iwait) trace.push_back(2);
    endtask

    task automatic tick();
        if (owner != 0 && m_rs == ERROR) err_m = 1;
        if (owner == 1) begin
            if (!(m_dr || m_dw) || m_rs == ACCESS) owner = 0;
        end else if (owner == 2) begin
            if (!m_ir || m_rs == ACCESS) owner = 0;
        end else begin
            if ((m_dr || m_dw) && !(m_ir && streak >= STARVE_MAX)) begin
                owner  = 1;
                streak = m_ir ? ((streak + 1 > STARVE_MAX) ? STARVE_MAX : streak + 1) : 0;
            end else begin
                if (m_ir) owner = 2;
                streak = 0;
            end
        end
        @(negedge CLK);
    endtask

    task automatic cycle(input logic ir, input word_t ia, input logic dr, input logic dw,
                         input word_t da, input word_t ds, input ramstate_t rs, input word_t rl);
        drive_check(ir, ia, dr, dw, da, ds, rs, rl);
        tick();
    endtask

    initial begin
        int exp_order[6];
        logic ir, dr, dw;
        ramstate_t rs;
        int r;

        // Reset state
        do_reset();
        drive_check(0, 0, 0, 0, 0, 0, FREE, 0);
        check("rst_iwait",  32'(bus.iwait),  1);
        check("rst_dwait",  32'(bus.dwait),  1);
        check("rst_ramREN", 32'(bus.ramREN), 0);
        check("rst_ramWEN", 32'(bus.ramWEN), 0);
        check("rst_err",    32'(bus.err),    0);
        tick();

        // icache fetch: BUSY, BUSY, ACCESS
        do_reset();
        drive_check(1, 32'h40, 0, 0, 0, 0, FREE, 0);
        check("if_bubble_ren", 32'(bus.ramREN), 0);
        tick();
        repeat (2) begin
            drive_check(1, 32'h40, 0, 0, 0, 0, BUSY, 0);
            check("if_busy_ren",   32'(bus.ramREN), 1);
            check("if_busy_addr",  bus.ramaddr,     32'h40);
            check("if_busy_iwait", 32'(bus.iwait),  1);
            tick();
        end
        drive_check(1, 32'h40, 0, 0, 0, 0, ACCESS, 32'h8C010004);
        check("if_acc_iwait", 32'(bus.iwait), 0);
        check("if_acc_iload", bus.iload,      32'h8C010004);
        tick();
        drive_check(0, 32'h40, 0, 0, 0, 0, ACCESS, 0);
        check("if_after_iwait", 32'(bus.iwait), 1);
        tick();

        // Simultaneous requests: dcache first, IDLE bubble, then icache
        do_reset();
        cycle(1, 32'h40, 1, 0, 32'h100, 0, ACCESS, 32'h11);
        drive_check(1, 32'h40, 1, 0, 32'h100, 0, ACCESS, 32'h22);
        check("both_d_addr", bus.ramaddr, 32'h100);
        tick();
        drive_check(1, 32'h40, 0, 0, 32'h100, 0, ACCESS, 32'h33);
        check("both_bubble_ren", 32'(bus.ramREN), 0);
        tick();
        cycle(1, 32'h40, 0, 0, 32'h100, 0, ACCESS, 32'h44);
        check("both_len", trace.size(), 2);
        if (trace.size() == 2) begin
            check("both_first",  trace[0], 1);
            check("both_second", trace[1], 2);
        end

        // Starvation: continuous dcache writes with icache pending
        do_reset();
        repeat (12) cycle(1, 32'h80, 0, 1, 32'h300, 32'h5, ACCESS, 32'h77);
        exp_order = '{1, 1, 1, 1, 2, 1};
        check("starve_len", trace.size(), 6);
        for (int i = 0; i < 6 && i < trace.size(); i++)
            check("starve_order", trace[i], exp_order[i]);

        // Abort of a dcache write before ACCESS
        do_reset();
        cycle(0, 0, 0, 1, 32'h200, 32'hDEADBEEF, FREE, 0);
        drive_check(0, 0, 0, 1, 32'h200, 32'hDEADBEEF, BUSY, 0);
        check("abort_wen",   32'(bus.ramWEN), 1);
        check("abort_store", bus.ramstore,    32'hDEADBEEF);
        tick();
        drive_check(0, 0, 0, 0, 32'h200, 32'hDEADBEEF, BUSY, 0);
        check("abort_drop_wen", 32'(bus.ramWEN), 0);
        tick();
        drive_check(0, 0, 0, 0, 32'h200, 32'hDEADBEEF, ACCESS, 0);
        check("abort_idle_wen", 32'(bus.ramWEN), 0);
        check("abort_idle_dwait", 32'(bus.dwait), 1);
        tick();
        check("abort_no_done", trace.size(), 0);

        // ERROR during ISERV: sticky err, transfer still completes
        do_reset();
        cycle(1, 32'h44, 0, 0, 0, 0, FREE, 0);
        cycle(1, 32'h44, 0, 0, 0, 0, ERROR, 0);
        drive_check(1, 32'h44, 0, 0, 0, 0, ACCESS, 32'h1234);
        check("errc_iwait", 32'(bus.iwait), 0);
        tick();
        repeat (2) begin
            drive_check(0, 0, 0, 0, 0, 0, FREE, 0);
            check("err_sticky", 32'(bus.err), 1);
            tick();
        end
        do_reset();
        drive_check(0, 0, 0, 0, 0, 0, FREE, 0);
        check("err_cleared", 32'(bus.err), 0);
        tick();

        // Randomized traffic against the reference model
        do_reset();
        ir = 0; dr = 0; dw = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) ir = ~ir;
            if ($urandom_range(0, 4) == 0) dr = ~dr;
            if ($urandom_range(0, 5) == 0) dw = ~dw;
            r = $urandom_range(0, 9);
            if (r == 0)      rs = ERROR;
            else if (r < 4)  rs = BUSY;
            else if (r < 6)  rs = FREE;
            else             rs = ACCESS;
            if (c == 1500) begin
                do_reset();
                drive_check(0, 0, 0, 0, 0, 0, FREE, 0);
                tick();
            end
            cycle(ir, $urandom, dr, dw, $urandom, $urandom, rs, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
